pc_fetch_sequencer: RTL and testbench

//  Program-counter and fetch-phase sequencer for the RISC datapath.

---
 rtl/pc_fetch_sequencer_pkg.sv | 27 ++
 rtl/pc_fetch_sequencer_reg_nbit.sv | 25 ++
 rtl/pc_fetch_sequencer.sv | 128 ++++++++++++
 tb/tb_pc_fetch_sequencer.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/pc_fetch_sequencer_pkg.sv
// Shared definitions for the PC / fetch-phase sequencer: phase encodings,
// default parameter values and the phase-advance helper.
package pc_fetch_sequencer_pkg;

    typedef enum logic [1:0] {
        PH_FETCH   = 2'b00,
        PH_DECODE  = 2'b01,
        PH_EXEC    = 2'b10,
        PH_ILLEGAL = 2'b11
    } phase_e;

    localparam int DEF_WIDTH     = 8;
    localparam int DEF_RESET_VEC = 0;
    localparam int DEF_STEP      = 1;

    // Any unexpected encoding falls back to FETCH so the sequencer self-recovers.
    function automatic phase_e phase_advance(input phase_e cur);
        phase_e nxt;
        case (cur)
            PH_FETCH:  nxt = PH_DECODE;
            PH_DECODE: nxt = PH_EXEC;
            default:   nxt = PH_FETCH;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/pc_fetch_sequencer_reg_nbit.sv
// WIDTH-wide bank of falling-edge flip-flops with asynchronous active-low reset;
// each bit resets to the matching bit of RESET_VAL.
module pc_fetch_sequencer_reg_nbit #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(negedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_q <= RESET_VAL;
        end else begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Program counter and 3-phase FETCH/DECODE/EXEC sequencer, falling-edge clocked.
// Optional macro BRANCH_REL_EN adds i_rel for PC-relative branches.
module pc_fetch_sequencer
    import pc_fetch_sequencer_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int RESET_VEC = DEF_RESET_VEC,
    parameter int STEP      = DEF_STEP
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic             i_ld,
`ifdef BRANCH_REL_EN
    input  logic             i_rel,
`endif
    input  logic [WIDTH-1:0] i_ld_val,
    output logic [WIDTH-1:0] o_pc,
    output logic [1:0]       o_phase,
    output logic             o_wrap
);

    logic [1:0]       w_phase_q;
    logic [1:0]       w_phase_d;
    phase_e           w_phase;
    phase_e           w_phase_next;
    logic [WIDTH-1:0] w_pc_q;
    logic [WIDTH-1:0] w_pc_d;
    logic [0:0]       w_wrap_q;
    logic [0:0]       w_wrap_d;
    logic             w_exec_upd;
    logic             w_abs_load;
    logic             w_rel_load;
    logic [WIDTH-1:0] w_addend;
    logic [WIDTH-1:0] w_sum;
    logic             w_carry_out;
    logic             w_overflow;

    assign w_phase = phase_e'(w_phase_q);

    pc_fetch_sequencer_reg_nbit #(
        .WIDTH     (2),
        .RESET_VAL (PH_FETCH)
    ) u_phase_reg (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_d     (w_phase_d),
        .o_q     (w_phase_q)
    );

    pc_fetch_sequencer_reg_nbit #(
        .WIDTH     (WIDTH),
        .RESET_VAL (WIDTH'(RESET_VEC))
    ) u_pc_reg (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_d     (w_pc_d),
        .o_q     (w_pc_q)
    );

    pc_fetch_sequencer_reg_nbit #(
        .WIDTH     (1),
        .RESET_VAL (1'b0)
    ) u_wrap_reg (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_d     (w_wrap_d),
        .o_q     (w_wrap_q)
    );

    always_comb begin
        w_phase_next = w_phase;
        if (w_phase == PH_ILLEGAL) begin
            w_phase_next = PH_FETCH;
        end else if (i_en) begin
            w_phase_next = phase_advance(w_phase);
        end
    end

    assign w_phase_d  = w_phase_next;
    assign w_exec_upd = i_en && (w_phase == PH_EXEC);

    // Without the macro w_rel_load is tied low, so the addend mux folds to STEP.
`ifdef BRANCH_REL_EN
    assign w_rel_load = i_ld & i_rel;
`else
    assign w_rel_load = 1'b0;
`endif
    assign w_abs_load = i_ld & ~w_rel_load;
    assign w_addend   = w_rel_load ? i_ld_val : WIDTH'(STEP);

    always_comb begin
        logic w_carry;
        w_carry = 1'b0;
        w_sum   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_sum[i] = w_pc_q[i] ^ w_addend[i] ^ w_carry;
            w_carry  = (w_pc_q[i] & w_addend[i]) | (w_carry & (w_pc_q[i] ^ w_addend[i]));
        end
        w_carry_out = w_carry;
        w_overflow  = (w_pc_q[WIDTH-1] == w_addend[WIDTH-1]) &&
                      (w_sum[WIDTH-1] != w_pc_q[WIDTH-1]);
    end

    // WRAP survives only a stall; any other non-update edge clears it.
    always_comb begin
        w_pc_d   = w_pc_q;
        w_wrap_d = w_wrap_q;
        if (w_exec_upd) begin
            if (w_abs_load) begin
                w_pc_d   = i_ld_val;
                w_wrap_d = 1'b0;
            end else begin
                w_pc_d   = w_sum;
                w_wrap_d = w_rel_load ? w_overflow : w_carry_out;
            end
        end else if (i_en) begin
            w_wrap_d = 1'b0;
        end
    end

    always_comb begin
        o_phase = (w_phase == PH_ILLEGAL) ? PH_FETCH : w_phase;
        o_pc    = w_pc_q;
        o_wrap  = w_wrap_q[0];
    end

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Directed table-driven bench for pc_fetch_sequencer (WIDTH=8, RESET_VEC=0, STEP=1);
// expected values follow BRANCH_REL_EN when that macro is defined.
module tb_pc_fetch_sequencer;

    typedef struct {
        logic       en;
        logic       ld;
        logic       rel;
        logic [7:0] ld_val;
        logic [7:0] exp_pc;
        logic [1:0] exp_phase;
        logic       exp_wrap;
        string      name;
    } vec_t;

`ifdef BRANCH_REL_EN
    localparam logic [7:0] EXP_REL_PC1  = 8'h08;
    localparam logic [7:0] EXP_REL_PC2  = 8'h87;
    localparam logic       EXP_REL_WRAP = 1'b1;
`else
    localparam logic [7:0] EXP_REL_PC1  = 8'hF8;
    localparam logic [7:0] EXP_REL_PC2  = 8'h7F;
    localparam logic       EXP_REL_WRAP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       ld;
    logic [7:0] ld_val;
    logic [7:0] pc;
    logic [1:0] phase;
    logic       wrap;
`ifdef BRANCH_REL_EN
    logic       rel;
`endif

    int   checks   = 0;
    int   failures = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    pc_fetch_sequencer #(
        .WIDTH     (8),
        .RESET_VEC (0),
        .STEP      (1)
    ) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_en     (en),
        .i_ld     (ld),
`ifdef BRANCH_REL_EN
        .i_rel    (rel),
`endif
        .i_ld_val (ld_val),
        .o_pc     (pc),
        .o_phase  (phase),
        .o_wrap   (wrap)
    );

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic checkAll(input string name, input logic [7:0] epc, input logic [1:0] eph,
                            input logic ewrap);
        checkOutput({name, ".pc"}, pc, epc);
        checkOutput({name, ".phase"}, {6'd0, phase}, {6'd0, eph});
        checkOutput({name, ".wrap"}, {7'd0, wrap}, {7'd0, ewrap});
    endtask

    task automatic applyStimulus(input vec_t v);
        en     = v.en;
        ld     = v.ld;
        ld_val = v.ld_val;
`ifdef BRANCH_REL_EN
        rel    = v.rel;
`endif
        @(negedge clk);
        #1;
    endtask

    task automatic addVec(input logic e, input logic l, input logic r, input logic [7:0] val,
                          input logic [7:0] epc, input logic [1:0] eph, input logic ewrap,
                          input string name);
        vec_t v;
        v.en = e; v.ld = l; v.rel = r; v.ld_val = val;
        v.exp_pc = epc; v.exp_phase = eph; v.exp_wrap = ewrap; v.name = name;
        vecs.push_back(v);
    endtask

    initial begin
        vec_t idle;
        idle.en = 1'b1; idle.ld = 1'b0; idle.rel = 1'b0; idle.ld_val = 8'h00;
        idle.exp_pc = 8'h00; idle.exp_phase = 2'b00; idle.exp_wrap = 1'b0; idle.name = "idle";

        // Run from reset: three full instruction cycles
        addVec(1, 0, 0, 8'h00, 8'h00, 2'b01, 0, "run1");
        addVec(1, 0, 0, 8'h00, 8'h00, 2'b10, 0, "run2");
        addVec(1, 0, 0, 8'h00, 8'h01, 2'b00, 0, "run3");
        addVec(1, 0, 0, 8'h00, 8'h01, 2'b01, 0, "run4");
        addVec(1, 0, 0, 8'h00, 8'h01, 2'b10, 0, "run5");
        addVec(1, 0, 0, 8'h00, 8'h02, 2'b00, 0, "run6");
        addVec(1, 0, 0, 8'h00, 8'h02, 2'b01, 0, "run7");
        addVec(1, 0, 0, 8'h00, 8'h02, 2'b10, 0, "run8");
        addVec(1, 0, 0, 8'h00, 8'h03, 2'b00, 0, "run9");
        // Branch: LD outside EXEC is ignored
        addVec(1, 1, 0, 8'h55, 8'h03, 2'b01, 0, "br_fetch");
        addVec(1, 1, 0, 8'hA0, 8'h03, 2'b10, 0, "br_decode");
        addVec(1, 1, 0, 8'hA0, 8'hA0, 2'b00, 0, "br_exec");
        // Stall in EXEC with a pending branch
        addVec(1, 0, 0, 8'h00, 8'hA0, 2'b01, 0, "st_pre1");
        addVec(1, 1, 0, 8'h5C, 8'hA0, 2'b10, 0, "st_pre2");
        for (int i = 0; i < 5; i++) addVec(0, 1, 0, 8'h5C, 8'hA0, 2'b10, 0, "stall");
        addVec(1, 1, 0, 8'h5C, 8'h5C, 2'b00, 0, "st_resume");
        addVec(0, 0, 0, 8'h00, 8'h5C, 2'b00, 0, "st_fetch");
        // Wrap from FF
        addVec(1, 0, 0, 8'h00, 8'h5C, 2'b01, 0, "wr_pre1");
        addVec(1, 0, 0, 8'h00, 8'h5C, 2'b10, 0, "wr_pre2");
        addVec(1, 1, 0, 8'hFF, 8'hFF, 2'b00, 0, "wr_ldff");
        addVec(1, 0, 0, 8'h00, 8'hFF, 2'b01, 0, "wr_pre3");
        addVec(1, 0, 0, 8'h00, 8'hFF, 2'b10, 0, "wr_pre4");
        addVec(1, 0, 0, 8'h00, 8'h00, 2'b00, 1, "wrap");
        addVec(0, 0, 0, 8'h00, 8'h00, 2'b00, 1, "wrap_stall");
        addVec(1, 0, 0, 8'h00, 8'h00, 2'b01, 0, "wrap_clear");
        // Relative branch (absolute when macro absent)
        addVec(1, 0, 0, 8'h00, 8'h00, 2'b10, 0, "rel_pre1");
        addVec(1, 1, 0, 8'h10, 8'h10, 2'b00, 0, "rel_ld10");
        addVec(1, 0, 0, 8'h00, 8'h10, 2'b01, 0, "rel_pre2");
        addVec(1, 0, 0, 8'h00, 8'h10, 2'b10, 0, "rel_pre3");
        addVec(1, 1, 1, 8'hF8, EXP_REL_PC1, 2'b00, 0, "rel_neg");
        addVec(1, 0, 0, 8'h00, EXP_REL_PC1, 2'b01, 0, "rel_pre4");
        addVec(1, 0, 0, 8'h00, EXP_REL_PC1, 2'b10, 0, "rel_pre5");
        addVec(1, 1, 1, 8'h7F, EXP_REL_PC2, 2'b00, EXP_REL_WRAP, "rel_ovf");
        addVec(1, 0, 0, 8'h00, EXP_REL_PC2, 2'b01, 0, "rel_clear");
        addVec(1, 0, 0, 8'h00, EXP_REL_PC2, 2'b10, 0, "abs_pre");
        addVec(1, 1, 0, 8'h37, 8'h37, 2'b00, 0, "abs_ld37");
        addVec(1, 0, 0, 8'h00, 8'h37, 2'b01, 0, "decode37");

        rst_n = 1'b0; en = 1'b1; ld = 1'b0; ld_val = 8'h00;
`ifdef BRANCH_REL_EN
        rel = 1'b0;
`endif
        #2;
        checkAll("reset_init", 8'h00, 2'b00, 1'b0);
        @(negedge clk);
        #1;
        checkAll("reset_hold", 8'h00, 2'b00, 1'b0);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            checkAll(vecs[i].name, vecs[i].exp_pc, vecs[i].exp_phase, vecs[i].exp_wrap);
        end

        // Asynchronous reset mid-DECODE with PC=37, no clock edge involved
        rst_n = 1'b0;
        #1;
        checkAll("reset_async", 8'h00, 2'b00, 1'b0);
        #2;
        rst_n = 1'b1;
        applyStimulus(idle);
        checkAll("post_reset1", 8'h00, 2'b01, 1'b0);
        applyStimulus(idle);
        checkAll("post_reset2", 8'h00, 2'b10, 1'b0);

        // Reset while in EXEC with a branch pending discards the update
        ld = 1'b1; ld_val = 8'h44;
        rst_n = 1'b0;
        #1;
        checkAll("reset_exec", 8'h00, 2'b00, 1'b0);
        @(negedge clk);
        #1;
        checkAll("reset_exec_edge", 8'h00, 2'b00, 1'b0);
        rst_n = 1'b1;
        applyStimulus(idle);
        checkAll("post_reset3", 8'h00, 2'b01, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
